// File: rtl/imem_ctrl_if.sv
// Memory-side valid/ready bus of the instruction-memory controller.
// The controller drives the request through the master modport; the memory model or PHY uses slave.
interface imem_ctrl_if #(
  parameter int unsigned XLEN = 32
);
  logic            mem_req;
  logic [XLEN-3:0] mem_addr;
  logic            mem_gnt;
  logic            mem_rvalid;
  logic [31:0]     mem_rdata;
  logic            mem_err;

  modport master (
    output mem_req, mem_addr,
    input  mem_gnt, mem_rvalid, mem_rdata, mem_err
  );

  modport slave (
    input  mem_req, mem_addr,
    output mem_gnt, mem_rvalid, mem_rdata, mem_err
  );
endinterface

// File: rtl/imem_ctrl.sv
// Single-outstanding instruction fetch controller: issues a request on the memory bus, returns
// one word with a one-cycle ack, drops cancelled responses and turns errors/timeouts into NOP+fault.
// Define IMEM_MISALIGN_CHECK_EN to fault misaligned fetch addresses instead of truncating them.
module imem_ctrl #(
  parameter int unsigned     XLEN           = 32,
  parameter logic [XLEN-1:0] MEM_BASE       = '0,
  parameter int unsigned     TIMEOUT_CYCLES = 255
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            i_inst_req,
  input  logic [XLEN-1:0] i_inst_req_addr,
  input  logic            i_abort,
  output logic [31:0]     o_inst_data,
  output logic            o_inst_ack,
  output logic            o_busy,
  output logic            o_fault,
  imem_ctrl_if.master     mem
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_REQ   = 3'd1;
  localparam logic [2:0] S_WAIT  = 3'd2;
  localparam logic [2:0] S_RESP  = 3'd3;
  localparam logic [2:0] S_DRAIN = 3'd4;

  localparam int unsigned      CNT_W    = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [31:0]      NOP      = 32'h0000_0013;

  logic [2:0]      state_q, state_d;
  logic [XLEN-3:0] addr_q, addr_d;
  logic [31:0]     data_q, data_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic            stale_q, stale_d;
  logic            fault_q, fault_d;

  logic [XLEN-1:0] rel_addr;
  logic            timeout;
  logic            misalign;

  assign rel_addr = i_inst_req_addr - MEM_BASE;
  // Count reaches TIMEOUT_CYCLES at the end of this cycle, i.e. TIMEOUT_CYCLES cycles in REQ+WAIT.
  assign timeout  = (cnt_q == CNT_LAST);

`ifdef IMEM_MISALIGN_CHECK_EN
  assign misalign = |i_inst_req_addr[1:0];
`else
  assign misalign = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    data_d  = data_q;
    cnt_d   = cnt_q;
    stale_d = stale_q;
    fault_d = fault_q;
    case (state_q)
      S_IDLE: begin
        if (i_inst_req && !i_abort) begin
          addr_d  = (XLEN-2)'(rel_addr >> 2);
          cnt_d   = '0;
          stale_d = 1'b0;
          fault_d = 1'b0;
          if (misalign) begin
            state_d = S_RESP;
            data_d  = NOP;
            fault_d = 1'b1;
          end else begin
            state_d = S_REQ;
          end
        end
      end
      S_REQ: begin
        cnt_d   = cnt_q + 1'b1;
        stale_d = stale_q | i_abort;
        if (mem.mem_gnt) begin
          state_d = (stale_q || i_abort) ? S_DRAIN : S_WAIT;
        end else if (timeout) begin
          // Never granted, so no response can follow; a cancelled request just retires.
          if (stale_q || i_abort) begin
            state_d = S_IDLE;
          end else begin
            state_d = S_RESP;
            data_d  = NOP;
            fault_d = 1'b1;
          end
        end
      end
      S_WAIT: begin
        cnt_d = cnt_q + 1'b1;
        if (mem.mem_rvalid) begin
          if (i_abort) begin
            state_d = S_IDLE;
          end else begin
            state_d = S_RESP;
            data_d  = mem.mem_err ? NOP : mem.mem_rdata;
            fault_d = mem.mem_err;
          end
        end else if (i_abort) begin
          state_d = S_DRAIN;
        end else if (timeout) begin
          state_d = S_RESP;
          data_d  = NOP;
          fault_d = 1'b1;
        end
      end
      S_RESP:  state_d = S_IDLE;
      S_DRAIN: if (mem.mem_rvalid) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      data_q  <= '0;
      cnt_q   <= '0;
      stale_q <= 1'b0;
      fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      cnt_q   <= cnt_d;
      stale_q <= stale_d;
      fault_q <= fault_d;
    end
  end

  assign mem.mem_req  = (state_q == S_REQ);
  assign mem.mem_addr = addr_q;
  assign o_inst_data  = data_q;
  assign o_busy       = (state_q != S_IDLE);
  assign o_inst_ack   = (state_q == S_RESP) && !i_abort;
  assign o_fault      = (state_q == S_RESP) && fault_q && !i_abort;

endmodule

// File: tb/tb_imem_ctrl.sv
// Bench for imem_ctrl: directed scenarios plus randomized bus traffic against a transaction-level model.
module tb_imem_ctrl;
  localparam int unsigned XLEN = 32;
  localparam int unsigned TMO  = 8;
  localparam logic [31:0] BASE = 32'h0;
  localparam logic [31:0] NOP  = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst;
  logic        req, abort;
  logic [31:0] addr;
  logic [31:0] inst_data;
  logic        ack, busy, fault;

  imem_ctrl_if #(.XLEN(XLEN)) mem ();

  imem_ctrl #(.XLEN(XLEN), .MEM_BASE(BASE), .TIMEOUT_CYCLES(TMO)) dut (
    .i_clk(clk), .i_rst(rst), .i_inst_req(req), .i_inst_req_addr(addr), .i_abort(abort),
    .o_inst_data(inst_data), .o_inst_ack(ack), .o_busy(busy), .o_fault(fault), .mem(mem.master)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference: a request is outstanding (m_busy); it is either still being offered (not granted),
  // granted and awaited, granted but cancelled (response to discard), or being answered (m_resp).
  logic        m_busy, m_granted, m_cancel, m_resp, m_fault;
  int          m_age;
  logic [31:0] m_data;
  logic [29:0] m_addr;

  task automatic model_reset();
    m_busy = 0; m_granted = 0; m_cancel = 0; m_resp = 0; m_fault = 0;
    m_age = 0; m_data = '0; m_addr = '0;
  endtask

  task automatic model_tick();
    if (m_resp) begin
      m_resp = 0; m_busy = 0;
    end else if (!m_busy) begin
      if (req && !abort) begin
        m_busy = 1; m_granted = 0; m_cancel = 0; m_age = 0; m_fault = 0;
        m_addr = 30'((addr - BASE) >> 2);
`ifdef IMEM_MISALIGN_CHECK_EN
        if (addr[1:0] != 2'b00) begin m_resp = 1; m_data = NOP; m_fault = 1; end
`endif
      end
    end else if (!m_granted) begin
      m_cancel = m_cancel | abort;
      if (mem.mem_gnt) m_granted = 1;
      else if (m_age + 1 == TMO) begin
        if (m_cancel) m_busy = 0;
        else begin m_resp = 1; m_data = NOP; m_fault = 1; end
      end
      m_age++;
    end else if (m_cancel) begin
      if (mem.mem_rvalid) m_busy = 0;
    end else begin
      if (mem.mem_rvalid) begin
        if (abort) m_busy = 0;
        else begin
          m_resp = 1;
          m_data = mem.mem_err ? NOP : mem.mem_rdata;
          m_fault = mem.mem_err;
        end
      end else if (abort) m_cancel = 1;
      else if (m_age + 1 == TMO) begin m_resp = 1; m_data = NOP; m_fault = 1; end
      m_age++;
    end
  endtask

  task automatic compare_all();
    check("busy",  32'(busy),         32'(m_busy));
    check("mreq",  32'(mem.mem_req),  32'(m_busy && !m_granted && !m_resp));
    check("maddr", 32'(mem.mem_addr), 32'(m_addr));
    check("ack",   32'(ack),          32'(m_resp && !abort));
    check("fault", 32'(fault),        32'(m_resp && m_fault && !abort));
    check("data",  inst_data,         m_data);
  endtask

  task automatic drive(input logic rq, input logic [31:0] ad, input logic ab, input logic gn,
                       input logic rv, input logic [31:0] rd, input logic er);
    @(negedge clk);
    req = rq; addr = ad; abort = ab;
    mem.mem_gnt = gn; mem.mem_rvalid = rv; mem.mem_rdata = rd; mem.mem_err = er;
    #1;
    compare_all();
  endtask

  task automatic tick();
    @(posedge clk);
    model_tick();
  endtask

  task automatic cyc(input logic rq, input logic [31:0] ad, input logic ab, input logic gn,
                     input logic rv, input logic [31:0] rd, input logic er);
    drive(rq, ad, ab, gn, rv, rd, er);
    tick();
  endtask

  task automatic idle_inputs();
    req = 0; addr = '0; abort = 0;
    mem.mem_gnt = 0; mem.mem_rvalid = 0; mem.mem_rdata = '0; mem.mem_err = 0;
  endtask

  initial begin
    int ack_idx;
    idle_inputs();
    rst = 1;
    model_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    #1;
    compare_all();
    rst = 0;

    // Baseline: request at N, gnt at N+1, rvalid at N+2, ack at N+3.
    cyc(1, 32'h100, 0, 1, 0, 0, 0);
    drive(0, 0, 0, 1, 0, 0, 0);
    check("base_mreq", 32'(mem.mem_req), 32'd1);
    check("base_maddr", 32'(mem.mem_addr), 32'h40);
    tick();
    drive(0, 0, 0, 0, 1, 32'h0010_0093, 0);
    check("base_noack", 32'(ack), 32'd0);
    tick();
    drive(0, 0, 0, 0, 0, 0, 0);
    check("base_ack", 32'(ack), 32'd1);
    check("base_data", inst_data, 32'h0010_0093);
    tick();
    cyc(0, 0, 0, 0, 0, 0, 0);

    // Grant withheld for 5 cycles.
    cyc(1, 32'h2000, 0, 0, 0, 0, 0);
    repeat (5) cyc(0, 0, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 1, 0, 0, 0);
    cyc(0, 0, 0, 0, 1, 32'h1234_5678, 0);
    cyc(0, 0, 0, 0, 0, 0, 0);

    // Abort in WAIT; late response is discarded.
    cyc(1, 32'h300, 0, 1, 0, 0, 0);
    cyc(0, 0, 0, 1, 0, 0, 0);
    cyc(0, 0, 1, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 1, 32'hDEAD_BEEF, 0);
    drive(0, 0, 0, 0, 0, 0, 0);
    check("abort_noack", 32'(ack), 32'd0);
    check("abort_data", inst_data, 32'h1234_5678);
    tick();
    cyc(1, 32'h400, 0, 1, 0, 0, 0);
    cyc(0, 0, 0, 1, 0, 0, 0);
    cyc(0, 0, 0, 0, 1, 32'hCAFE_0001, 0);
    cyc(0, 0, 0, 0, 0, 0, 0);

    // Bus error -> NOP with fault pulse.
    cyc(1, 32'h500, 0, 1, 0, 0, 0);
    cyc(0, 0, 0, 1, 0, 0, 0);
    cyc(0, 0, 0, 0, 1, 32'hFFFF_FFFF, 1);
    drive(0, 0, 0, 0, 0, 0, 0);
    check("err_fault", 32'(fault), 32'd1);
    check("err_data", inst_data, NOP);
    tick();
    cyc(0, 0, 0, 0, 0, 0, 0);

    // Timeout in WAIT: ack lands TMO cycles after the request was first offered.
    cyc(1, 32'h600, 0, 1, 0, 0, 0);
    cyc(0, 0, 0, 1, 0, 0, 0);
    ack_idx = -1;
    for (int k = 0; k < 12; k++) begin
      drive(0, 0, 0, 0, 0, 0, 0);
      if (ack && ack_idx < 0) ack_idx = k;
      tick();
    end
    check("tmo_ack_idx", 32'(ack_idx), 32'(TMO - 1));
    cyc(0, 0, 0, 0, 1, 32'hBAD0_BAD0, 0);
    cyc(0, 0, 0, 0, 0, 0, 0);

    // Asynchronous reset while in WAIT.
    cyc(1, 32'h700, 0, 1, 0, 0, 0);
    cyc(0, 0, 0, 1, 0, 0, 0);
    drive(0, 0, 0, 0, 0, 0, 0);
    #2 rst = 1;
    #1;
    check("arst_busy", 32'(busy), 32'd0);
    check("arst_mreq", 32'(mem.mem_req), 32'd0);
    check("arst_maddr", 32'(mem.mem_addr), 32'd0);
    check("arst_data", inst_data, 32'd0);
    check("arst_ack", 32'(ack), 32'd0);
    @(posedge clk);
    model_reset();
    @(negedge clk);
    rst = 0;
    cyc(0, 0, 0, 0, 1, 32'h5555_AAAA, 0);
    cyc(0, 0, 0, 0, 0, 0, 0);

`ifdef IMEM_MISALIGN_CHECK_EN
    drive(1, 32'h102, 0, 0, 0, 0, 0);
    tick();
    drive(0, 0, 0, 0, 0, 0, 0);
    check("mis_mreq", 32'(mem.mem_req), 32'd0);
    check("mis_ack", 32'(ack), 32'd1);
    check("mis_fault", 32'(fault), 32'd1);
    tick();
    cyc(0, 0, 0, 0, 0, 0, 0);
`endif

    // Randomized traffic with per-block probabilities so timeouts, aborts and errors all occur.
    for (int blk = 0; blk < 15; blk++) begin
      int pg, pr, pa, pe;
      pg = $urandom_range(90, 15);
      pr = (blk % 4 == 3) ? 3 : $urandom_range(70, 10);
      pa = $urandom_range(10, 0);
      pe = $urandom_range(30, 0);
      for (int c = 0; c < 200; c++) begin
        cyc(($urandom_range(99, 0) < 60), $urandom, ($urandom_range(99, 0) < pa),
            ($urandom_range(99, 0) < pg), ($urandom_range(99, 0) < pr), $urandom,
            ($urandom_range(99, 0) < pe));
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
